// File: rtl/fft_cmul_sched.sv
// fft_cmul_sched: Karatsuba complex multiply z = x*w for an FFT twiddle stage.
// A single real multiplier is time-shared over three cycles (P0..P2); a
// valid/ready handshake on both sides lets an SDF stage or twiddle-ROM front
// end drive it. One result per 4 cycles when streaming.
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   in_valid_i / in_ready_o     operand handshake (x, w, ctr accepted together)
//   ctr_i                       sample counter/tag travelling with the operands
//   x_re_i, x_im_i              signed data sample, DW bits
//   w_re_i, w_im_i              signed twiddle, Q1.(TWIDDLE_WIDTH-1)
//   out_valid_o / out_ready_i   result handshake
//   ctr_o                       tag of the result on z
//   z_re_o, z_im_o              signed product scaled by 2^-(TWIDDLE_WIDTH-1)
//
// Build option: define FFT_CMUL_ROUND_EN for round-half-up with positive
// saturation; otherwise the result is truncated (floor).
module fft_cmul_sched #(
  parameter int unsigned DW            = 25,
  parameter int unsigned TWIDDLE_WIDTH = 10,
  parameter int unsigned NLOG2         = 10
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [NLOG2-1:0]         ctr_i,
  input  logic [DW-1:0]            x_re_i,
  input  logic [DW-1:0]            x_im_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_re_i,
  input  logic [TWIDDLE_WIDTH-1:0] w_im_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [NLOG2-1:0]         ctr_o,
  output logic [DW-1:0]            z_re_o,
  output logic [DW-1:0]            z_im_o
);

  localparam int unsigned TW  = TWIDDLE_WIDTH;
  localparam int unsigned PW  = DW + TW;      // product / accumulator width
  localparam int unsigned PFW = DW + TW + 2;  // full multiplier result width

  typedef enum logic [2:0] {StIdle, StP0, StP1, StP2, StHold} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     x_re_q, x_re_d, x_im_q, x_im_d;
  logic [TW-1:0]     w_re_q, w_re_d, w_im_q, w_im_d;
  logic [NLOG2-1:0]  ctr_q, ctr_d, ctr_out_q, ctr_out_d;
  logic [PW-1:0]     f_q, f_d, r_q, r_d;
  logic [DW-1:0]     z_re_q, z_re_d, z_im_q, z_im_d;
  logic              out_valid_q, out_valid_d;

  logic              accept;
  logic [DW:0]       mul_a;   // data-side operand (one bit of growth)
  logic [TW:0]       mul_b;   // twiddle-side operand (one bit of growth)
  logic [PFW-1:0]    mul_a_ext, mul_b_ext, prod_full;
  logic [PW-1:0]     prod, i_d;
  logic [DW-1:0]     z_re_scaled, z_im_scaled;

  assign in_ready_o = (state_q == StIdle) | ((state_q == StHold) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  // Operand mux in front of the one shared multiplier.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      StP0: begin
        mul_a = {x_re_q[DW-1], x_re_q} - {x_im_q[DW-1], x_im_q};
        mul_b = {w_re_q[TW-1], w_re_q};
      end
      StP1: begin
        mul_a = {x_im_q[DW-1], x_im_q};
        mul_b = {w_re_q[TW-1], w_re_q} - {w_im_q[TW-1], w_im_q};
      end
      StP2: begin
        mul_a = {x_re_q[DW-1], x_re_q};
        mul_b = {w_re_q[TW-1], w_re_q} + {w_im_q[TW-1], w_im_q};
      end
      default: ;
    endcase
  end

  assign mul_a_ext = {{(TW + 1){mul_a[DW]}}, mul_a};
  assign mul_b_ext = {{(DW + 1){mul_b[TW]}}, mul_b};
  assign prod_full = $signed(mul_a_ext) * $signed(mul_b_ext);
  assign prod      = prod_full[PW-1:0];
  assign i_d       = prod - f_q;

`ifdef FFT_CMUL_ROUND_EN
  localparam logic [PW:0]   RoundInc = {{(PW - TW + 2){1'b0}}, 1'b1, {(TW - 2){1'b0}}};
  localparam logic [DW+1:0] ZMax     = {3'b000, {(DW - 1){1'b1}}};

  logic [PW:0]   rnd_re, rnd_im;
  logic [DW+1:0] top_re, top_im;
  logic          unused_bits;

  assign rnd_re = {r_q[PW-1], r_q} + RoundInc;
  assign rnd_im = {i_d[PW-1], i_d} + RoundInc;
  assign top_re = rnd_re[PW:TW-1];
  assign top_im = rnd_im[PW:TW-1];
  // Rounding only adds, so only the positive rail can be crossed.
  assign z_re_scaled = ($signed(top_re) > $signed(ZMax)) ? ZMax[DW-1:0] : top_re[DW-1:0];
  assign z_im_scaled = ($signed(top_im) > $signed(ZMax)) ? ZMax[DW-1:0] : top_im[DW-1:0];
  assign unused_bits = ^{rnd_re[TW-2:0], rnd_im[TW-2:0], prod_full[PFW-1:PW]};
`else
  logic unused_bits;

  assign z_re_scaled = r_q[PW-2:TW-1];
  assign z_im_scaled = i_d[PW-2:TW-1];
  assign unused_bits = ^{r_q[PW-1], r_q[TW-2:0], i_d[PW-1], i_d[TW-2:0],
                         prod_full[PFW-1:PW]};
`endif

  always_comb begin
    state_d     = state_q;
    x_re_d      = x_re_q;
    x_im_d      = x_im_q;
    w_re_d      = w_re_q;
    w_im_d      = w_im_q;
    ctr_d       = ctr_q;
    f_d         = f_q;
    r_d         = r_q;
    z_re_d      = z_re_q;
    z_im_d      = z_im_q;
    ctr_out_d   = ctr_out_q;
    out_valid_d = out_valid_q;

    if (accept) begin
      x_re_d = x_re_i;
      x_im_d = x_im_i;
      w_re_d = w_re_i;
      w_im_d = w_im_i;
      ctr_d  = ctr_i;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) state_d = StP0;
      end
      StP0: begin
        f_d     = prod;
        state_d = StP1;
      end
      StP1: begin
        r_d     = prod + f_q;
        state_d = StP2;
      end
      StP2: begin
        z_re_d      = z_re_scaled;
        z_im_d      = z_im_scaled;
        ctr_out_d   = ctr_q;
        out_valid_d = 1'b1;
        state_d     = StHold;
      end
      StHold: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = accept ? StP0 : StIdle;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      x_re_q      <= '0;
      x_im_q      <= '0;
      w_re_q      <= '0;
      w_im_q      <= '0;
      ctr_q       <= '0;
      f_q         <= '0;
      r_q         <= '0;
      z_re_q      <= '0;
      z_im_q      <= '0;
      ctr_out_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_re_q      <= x_re_d;
      x_im_q      <= x_im_d;
      w_re_q      <= w_re_d;
      w_im_q      <= w_im_d;
      ctr_q       <= ctr_d;
      f_q         <= f_d;
      r_q         <= r_d;
      z_re_q      <= z_re_d;
      z_im_q      <= z_im_d;
      ctr_out_q   <= ctr_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign z_re_o      = z_re_q;
  assign z_im_o      = z_im_q;
  assign ctr_o       = ctr_out_q;

endmodule
